// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - bus initiator that fills main RAM from a byte stream and optionally verifies it
//
// Purpose:
//   Requests the RAM bus from the CPU through a hold handshake. Once granted, it
//   writes a byte stream into consecutive RAM addresses and keeps a mod-256
//   checksum. When VERIFY is non-zero it then reads the image back and compares
//   the read-back sum with the checksum. Finally it releases the bus and pulses done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a load (IDLE only) / cancel a load in progress
//   base_addr, length   first RAM address and byte count, latched on start
//   s_data/s_valid/s_ready  byte stream input with valid/ready handshake
//   hold_req, hold_ack  bus request to the CPU / bus granted by the CPU
//   ram_a, ram_din, ram_dout, ram_we, ram_ce  synchronous RAM port
//   busy, done, err, checksum  status outputs

module ram_loader #(
  parameter int VERIFY = 1,
  parameter int AW     = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          hold_req,
  input  logic          hold_ack,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic          ram_we,
  output logic          ram_ce,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    checksum
);

  // S_DRAIN is the tail of the read-back pass: no read is issued, only the
  // final byte returned by the RAM is captured and the sums are compared.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WRITE,
    S_VERIFY,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam logic [AW:0] REM_ONE = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    rsum_q, rsum_d;
  logic          err_q, err_d;
  logic          rd_pend_q, rd_pend_d;
  logic [7:0]    rsum_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      rsum_q    <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      rsum_q    <= rsum_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // In S_DRAIN the last read is always outstanding, so its data is added unconditionally.
  assign rsum_final = rsum_q + ram_dout;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    rem_d     = rem_q;
    len_d     = len_q;
    csum_d    = csum_q;
    rsum_d    = rsum_q;
    err_d     = err_q;
    rd_pend_d = 1'b0;

    s_ready   = 1'b0;
    hold_req  = 1'b0;
    ram_a     = '0;
    ram_din   = '0;
    ram_we    = 1'b0;
    ram_ce    = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start outranks abort here; abort has no meaning while idle.
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          addr_d = base_addr;
          rem_d  = length;
          csum_d = '0;
          rsum_d = '0;
          err_d  = 1'b0;
          if (length == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        hold_req = 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (hold_ack) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        hold_req = 1'b1;
        // Abort and loss of the bus both end the load before any strobe this cycle.
        if (abort || !hold_ack) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            ram_ce  = 1'b1;
            ram_we  = 1'b1;
            ram_a   = addr_q;
            ram_din = s_data;
            csum_d  = csum_q + s_data;
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == REM_ONE) begin
              if (VERIFY != 0) begin
                addr_d  = base_q;
                rem_d   = len_q;
                rsum_d  = '0;
                state_d = S_VERIFY;
              end else begin
                state_d = S_FINISH;
              end
            end
          end
        end
      end

      S_VERIFY: begin
        hold_req = 1'b1;
        if (abort || !hold_ack) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          // Issue this cycle's read and fold in the data of the previous one.
          ram_ce    = 1'b1;
          ram_a     = addr_q;
          rd_pend_d = 1'b1;
          if (rd_pend_q) begin
            rsum_d = rsum_q + ram_dout;
          end
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        hold_req = 1'b1;
        if (abort || !hold_ack) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          rsum_d = rsum_final;
          if (rsum_final != csum_q) begin
            err_d = 1'b1;
          end
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign checksum = csum_q;

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Bus initiator that fills the 32 KB SPRAM-backed main RAM from a byte stream (UART/SD snapshot or .P file loader).
- Writes into the RAM's synchronous port.
- Optionally reads the image back to verify it.
- Sits beside the Z80: requests the bus through a hold handshake, drives the RAM address/data/write-enable/chip-select while granted, then releases the bus.

Parameters:
- VERIFY, 1, when 1 a read-back pass follows the write pass; when 0 the read-back pass is skipped.
- AW, 15, RAM word-address width; the address counter wraps modulo 2^AW.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  cancels a load in progress.
- base_addr  in  AW  first RAM address, latched on start.
- length  in  AW+1  byte count, 0..32768, latched on start.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts a byte this cycle.
- hold_req  out  1  bus request to the CPU.
- hold_ack  in  1  CPU has released the bus.
- ram_a  out  AW  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, valid one cycle after the address.
- ram_we  out  1  RAM write enable.
- ram_ce  out  1  RAM chip select.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  verify mismatch or abort; held until the next accepted start.
- checksum  out  8  mod-256 sum of the bytes written.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. hold_req, s_ready, ram_we, ram_ce, busy, done, err = 0; checksum = 0; ram_a = 0; internal counters = 0.
- IDLE:
  - start=1 latches base_addr into the address counter and length into the remaining count; clears checksum, err and the read-back sum.
  - If length=0: go to FINISH without raising hold_req.
  - Otherwise raise hold_req and go to HOLD.
- HOLD: hold_req=1; wait for hold_ack=1, then go to WRITE. No RAM access in this state.
- WRITE:
  - s_ready=1.
  - A byte transfers when s_valid and s_ready are both 1. In that same cycle, combinationally: ram_ce=1, ram_we=1, ram_a=address counter, ram_din=s_data.
  - On each transfer: checksum += s_data (mod 256), address +1 (wraps 2^AW-1 -> 0), remaining -1.
  - The transfer that brings remaining to 0 moves the state to VERIFY if VERIFY=1, otherwise to FINISH.
  - s_valid low stalls indefinitely with no RAM strobes.
- VERIFY:
  - Address counter reloads base_addr, remaining reloads length.
  - One read issues per cycle: ram_ce=1, ram_we=0, ram_a=counter.
  - Data for the read issued in cycle n is taken from ram_dout in cycle n+1 and added to the read-back sum.
  - After the last read issues, one drain cycle captures the final byte.
  - Then err is set if read-back sum != checksum, and the state goes to FINISH.
- FINISH: hold_req=0, done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- hold_req stays high from HOLD through VERIFY.
- hold_ack dropping mid-load is a protocol violation: it sets err and goes to FINISH. No RAM strobe is issued in the cycle hold_ack is seen low.
- abort=1 in HOLD/WRITE/VERIFY:
  - Next state is FINISH with err=1.
  - abort has priority over a simultaneous byte transfer: the byte is not accepted, s_ready=0 that cycle.
- start while busy is ignored. start and abort both high in IDLE: start wins, abort is ignored.
- ram_ce and ram_we are never high outside WRITE/VERIFY.
- length=32768 writes every RAM location exactly once, wrapping through 0.

Test Plan:
- base=0x4000, length=4, stream 0x11,0x22,0x33,0x44 with s_valid always high, RAM model echoing writes, VERIFY=1 -> four writes to 0x4000..0x4003, checksum=0xAA, err=0, done one cycle, hold_req low after FINISH.
- Same stimulus with the RAM model corrupting address 0x4002 on read-back -> err=1, done pulses once, checksum still 0xAA.
- base=0x7FFE, length=3, bytes 0xFF,0x01,0x02 -> writes at 0x7FFE, 0x7FFF, 0x0000; checksum=0x02.
- length=0 with start -> hold_req never asserts, done pulses one cycle after start, err=0.
- hold_ack delayed 10 cycles and s_valid toggling every other cycle -> no ram_we before hold_ack, exactly one write per valid handshake, none while s_valid is low.
- abort asserted after 2 of 8 bytes, and separately rst_n pulsed low mid-WRITE:
  - abort -> done and err=1, hold_req drops.
  - reset -> all outputs return to reset values immediately, with no clock edge required.
